dds_32: RTL and testbench

32-bit direct digital frequency synthesizer producing a time-multiplexed quadrature (cos/sin) local-oscillator stream for the transceiver's digital up/down converters. A 32-bit phase accumulator advances by `frq` once per sample. The top 12 phase bits address a quarter-wave sine ROM. The output word `doxy` alternates between cosine (I) and sine (Q) on consecutive `dclk` cycles, giving two words per sample period.

---
 rtl/dds_32_if.sv | 19 +
 rtl/dds_32.sv | 105 ++++++++++
 tb/tb_dds_32.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dds_32_if.sv
// Sample-stream bus of the DDS: slot phase and tuning word in, interleaved cos/sin out.
// The master drives iq/frq and consumes doxy; the synthesizer is the slave.
interface dds_32_if;
    logic        iq;
    logic [31:0] frq;
    logic [17:0] doxy;

    modport master (
        output iq,
        output frq,
        input  doxy
    );

    modport slave (
        input  iq,
        input  frq,
        output doxy
    );
endinterface

// File: rtl/dds_32.sv
// 32-bit DDS: phase accumulator plus quarter-wave sine ROM, emitting cos on the I slot
// and sin on the following Q slot of the same accumulator value, three dclk cycles later.
module dds_32 (
    input  logic    dclk,
    input  logic    rst,
    dds_32_if.slave bus
);
    localparam int  ROM_DEPTH = 1024;
    localparam int  AMP       = 131071;
    localparam real PI        = 3.14159265358979323846;

    function automatic real sin_series(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Half-step offset keeps every entry nonzero, so the output never crosses through 0.
    function automatic logic [16:0] rom_entry(input int k);
        real ang;
        ang = 2.0 * PI * (real'(k) + 0.5) / 4096.0;
        return 17'($rtoi(real'(AMP) * sin_series(ang) + 0.5));
    endfunction

    logic [16:0] rom [ROM_DEPTH];

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        localparam logic [16:0] ROM_VAL = rom_entry(k);
        assign rom[k] = ROM_VAL;
    end

    logic        sample;
    logic [11:0] phase;
    logic [9:0]  quad_idx;
    logic [17:0] mag;

    logic [31:0] acc_d,      acc_q;
    logic        started_d,  started_q;
    logic [11:0] addr_d,     addr_q;
    logic        addr_vld_d, addr_vld_q;
    logic [16:0] rom_d,      rom_q;
    logic        neg_d,      neg_q;
    logic        rom_vld_d,  rom_vld_q;
    logic [17:0] doxy_d,     doxy_q;

    // The I-slot edge addresses cos of the settled accumulator; the following sample
    // edge addresses sin of that same value, before the accumulator moves on.
    always_comb begin
        sample    = bus.iq;
        acc_d     = acc_q;
        started_d = started_q;
        if (sample) begin
            acc_d     = acc_q + bus.frq;
            started_d = 1'b1;
        end

        phase      = acc_q[31:20];
        addr_d     = sample ? phase : phase + 12'd1024;
        addr_vld_d = started_q;

        quad_idx  = addr_q[10] ? ~addr_q[9:0] : addr_q[9:0];
        rom_d     = rom[quad_idx];
        neg_d     = addr_q[11];
        rom_vld_d = addr_vld_q;

        mag = {1'b0, rom_q};
        if (!rom_vld_q) begin
            doxy_d = '0;
        end else if (neg_q) begin
            doxy_d = -mag;
        end else begin
            doxy_d = mag;
        end
    end

    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            started_q  <= 1'b0;
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            rom_q      <= '0;
            neg_q      <= 1'b0;
            rom_vld_q  <= 1'b0;
            doxy_q     <= '0;
        end else begin
            acc_q      <= acc_d;
            started_q  <= started_d;
            addr_q     <= addr_d;
            addr_vld_q <= addr_vld_d;
            rom_q      <= rom_d;
            neg_q      <= neg_d;
            rom_vld_q  <= rom_vld_d;
            doxy_q     <= doxy_d;
        end
    end

    assign bus.doxy = doxy_q;
endmodule

// File: tb/tb_dds_32.sv
// Directed bench for dds_32: reset, static phase, Nyquist, slow tone with a frequency
// freeze, and an asynchronous mid-run reset, all against hand-computed ROM values.
module tb_dds_32;
    logic dclk = 1'b0;
    logic rst;

    dds_32_if bus ();

    dds_32 dut (
        .dclk (dclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 dclk = ~dclk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d (0x%h) expected %0d (0x%h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    // Runs n samples with no checking; frq carries junk on the Q slot, which must be ignored.
    task automatic applyStimulus(input logic [31:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus.iq  = 1'b1;
            bus.frq = f;
            @(negedge dclk);
            bus.iq  = 1'b0;
            bus.frq = 32'hDEAD_BEEF;
            @(negedge dclk);
        end
    endtask

    // One sample: its sample edge shows sin of two samples back, its Q edge cos of the previous one.
    task automatic stepSample(input logic [31:0] f, input int sinExp, input int cosExp,
                              input string tag);
        bus.iq  = 1'b1;
        bus.frq = f;
        @(negedge dclk);
        checkOutput({tag, "_sin"}, int'($signed(bus.doxy)), sinExp);
        bus.iq  = 1'b0;
        bus.frq = 32'hDEAD_BEEF;
        @(negedge dclk);
        checkOutput({tag, "_cos"}, int'($signed(bus.doxy)), cosExp);
    endtask

    task automatic resetDut();
        bus.iq = 1'b0;
        rst    = 1'b0;
        #2;
        rst    = 1'b1;
        @(negedge dclk);
    endtask

    initial begin
        rst     = 1'b0;
        bus.iq  = 1'b0;
        bus.frq = 32'h0001_0000;
        @(negedge dclk);

        $display("[TB] reset hold and release");
        applyStimulus(32'h0001_0000, 3);
        checkOutput("rst_hold_doxy", int'($signed(bus.doxy)), 0);
        checkOutput("rst_hold_acc", int'(dut.acc_q), 0);
        rst = 1'b1;
        stepSample(32'h0001_0000, 0, 0, "rel1");
        stepSample(32'h0001_0000, 0, 131071, "rel2");
        stepSample(32'h0001_0000, 101, 131071, "rel3");

        $display("[TB] static phase");
        resetDut();
        stepSample(32'h0, 0, 0, "stat1");
        stepSample(32'h0, 0, 131071, "stat2");
        for (int i = 0; i < 3; i++) begin
            stepSample(32'h0, 101, 131071, "stat_run");
        end
        checkOutput("stat_acc", int'(dut.acc_q), 0);

        $display("[TB] nyquist");
        resetDut();
        stepSample(32'h8000_0000, 0, 0, "nyq1");
        stepSample(32'h8000_0000, 0, -131071, "nyq2");
        stepSample(32'h8000_0000, -101, 131071, "nyq3");
        stepSample(32'h8000_0000, 101, -131071, "nyq4");
        stepSample(32'h8000_0000, -101, 131071, "nyq5");

        $display("[TB] asynchronous mid-run reset");
        #1;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_doxy", int'($signed(bus.doxy)), 0);
        checkOutput("mid_rst_acc", int'(dut.acc_q), 0);
        #1;
        rst = 1'b1;
        @(negedge dclk);
        stepSample(32'h8000_0000, 0, 0, "restart1");
        stepSample(32'h8000_0000, 0, -131071, "restart2");
        stepSample(32'h8000_0000, -101, 131071, "restart3");

        $display("[TB] slow tone with frequency freeze");
        resetDut();
        applyStimulus(32'h0001_0000, 8192);
        checkOutput("frz_before", int'(dut.acc_q), 32'h2000_0000);
        applyStimulus(32'h0, 2);
        checkOutput("frz_hold", int'(dut.acc_q), 32'h2000_0000);
        applyStimulus(32'h0001_0000, 1);
        checkOutput("frz_resume", int'(dut.acc_q), 32'h2001_0000);
        applyStimulus(32'h0001_0000, 8191);
        stepSample(32'h0001_0000, 131071, -101, "quarter_a");
        stepSample(32'h0001_0000, 131071, -101, "quarter_b");
        applyStimulus(32'h0001_0000, 8614);
        stepSample(32'h0001_0000, 88838, -96371, "tone_a");
        stepSample(32'h0001_0000, 88838, -96371, "tone_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
